// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: write-back source select, access size
// and the controller FSM states.
package mem_pkg;

  localparam logic [1:0] WB_PC  = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and
// the memory (slave).
interface mem_stage_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_load_align.sv
// Picks one byte lane out of a read word and sign- or zero-extends it to the
// full datapath width.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0]             rdata,
  input  logic [$clog2(DW/8)-1:0]   lane,
  input  logic                      is_signed,
  output logic [DW-1:0]             ld_val
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    ld_val   = is_signed ? {{(DW-8){byte_sel[7]}}, byte_sel}
                         : {{(DW-8){1'b0}}, byte_sel};
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Pipeline memory stage: issues one request per load/store, stalls upstream
// while it is outstanding, steers store lanes and formats the write-back value.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        alu_result,
  input  logic [DW-1:0]        store_data,
  input  logic [DW-1:0]        immediate,
  input  logic [DW-1:0]        pc,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic                 size,
  input  logic                 load_signed,
  input  logic                 st_src,
  input  logic [1:0]           wb_sel,
  mem_stage_ctrl_if.master     mem,
  output logic                 stall,
  output logic                 wb_valid,
  output logic [DW-1:0]        wb_data,
  output logic                 wb_err
);

  localparam int BW = DW / 8;
  localparam int LW = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]     mem_be_q, mem_be_d;
  logic              wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;

  // Instruction fields captured at acceptance for use when the ack returns.
  logic [1:0]        op_wb_sel_q, op_wb_sel_d;
  logic              op_size_q, op_size_d, op_signed_q, op_signed_d, op_rd_q, op_rd_d;
  logic [LW-1:0]     op_lane_q, op_lane_d;
  logic [DW-1:0]     op_pc_q, op_pc_d, op_alu_q, op_alu_d, op_imm_q, op_imm_d;

  logic              mem_op, aligned, accept;
  logic [LW-1:0]     in_lane;
  logic [DW-1:0]     src, byte_ext, ld_val;

  function automatic logic [DW-1:0] wb_pick(input logic [1:0] sel, input logic [DW-1:0] p,
                                            input logic [DW-1:0] a, input logic [DW-1:0] l,
                                            input logic [DW-1:0] i);
    case (sel)
      WB_PC:   return p;
      WB_ALU:  return a;
      WB_MEM:  return l;
      default: return i;
    endcase
  endfunction

  mem_load_align #(.DW(DW)) u_load_align (
    .rdata     (mem.mem_rdata),
    .lane      (op_lane_q),
    .is_signed (op_signed_q),
    .ld_val    (byte_ext)
  );

  assign mem_op  = mem_rd | mem_wr;
  assign in_lane = alu_result[LW-1:0];
  assign aligned = (size == SZ_BYTE) || (in_lane == '0);
  assign accept  = (state_q == ST_IDLE) && in_valid && mem_op && aligned;
  assign stall   = (state_q == ST_WAIT) || accept;
  assign src     = st_src ? store_data : immediate;
  assign ld_val  = !op_rd_q ? '0 : ((op_size_q == SZ_WORD) ? mem.mem_rdata : byte_ext);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_err_d    = 1'b0;
    wb_data_d   = wb_data_q;
    op_wb_sel_d = op_wb_sel_q;
    op_size_d   = op_size_q;
    op_signed_d = op_signed_q;
    op_rd_d     = op_rd_q;
    op_lane_d   = op_lane_q;
    op_pc_d     = op_pc_q;
    op_alu_d    = op_alu_q;
    op_imm_d    = op_imm_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !mem_op) begin
          wb_valid_d = 1'b1;
          wb_data_d  = wb_pick(wb_sel, pc, alu_result, '0, immediate);
        end else if (in_valid && !aligned) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
        end else if (accept) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_wr;
          mem_addr_d  = AW'(alu_result);
          mem_be_d    = '1;
          mem_wdata_d = '0;
          if (mem_wr) begin
            mem_wdata_d = (size == SZ_WORD) ? src : {BW{src[7:0]}};
            if (size == SZ_BYTE) mem_be_d = BW'(1) << in_lane;
          end
          op_wb_sel_d = wb_sel;
          op_size_d   = size;
          op_signed_d = load_signed;
          op_rd_d     = mem_rd;
          op_lane_d   = in_lane;
          op_pc_d     = pc;
          op_alu_d    = alu_result;
          op_imm_d    = immediate;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the final allowed cycle still completes normally.
        if (mem.mem_ack) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = wb_pick(op_wb_sel_q, op_pc_q, op_alu_q, ld_val, op_imm_q);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_err_q    <= wb_err_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    op_wb_sel_q <= op_wb_sel_d;
    op_size_q   <= op_size_d;
    op_signed_q <= op_signed_d;
    op_rd_q     <= op_rd_d;
    op_lane_q   <= op_lane_d;
    op_pc_q     <= op_pc_d;
    op_alu_q    <= op_alu_d;
    op_imm_q    <= op_imm_d;
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl (DW=16, AW=16, TIMEOUT=4): directed cases followed by
// random instructions, each compared against an arithmetic reference model.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, mem_rd, mem_wr, size, load_signed, st_src;
  logic [15:0] alu_result, store_data, immediate, pc;
  logic [1:0]  wb_sel;
  logic        stall, wb_valid, wb_err;
  logic [15:0] wb_data;
  int          checks = 0;
  int          failures = 0;

  mem_stage_ctrl_if #(.DW(16), .AW(16)) mif ();

  mem_stage_ctrl #(.DW(16), .AW(16), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .immediate   (immediate),
    .pc          (pc),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .size        (size),
    .load_signed (load_signed),
    .st_src      (st_src),
    .wb_sel      (wb_sel),
    .mem         (mif),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction at posedge+1, services the memory with an ack in
  // WAIT cycle 'lat' (0 = never) and checks the whole transaction.
  task automatic do_op(input logic rd, input logic wr, input logic sz, input logic sgn,
                       input logic ssrc, input logic [1:0] sel, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [15:0] imm, input logic [15:0] p,
                       input logic [15:0] rdat, input int lat, input bit gap);
    int lane, b, exp_lat, done, stall_cnt, req_cnt;
    bit acc, tmo, exp_err;
    logic [15:0] src, ld, exp_data, exp_wd;
    logic [1:0]  exp_be;
    lane    = int'(alu[0]);
    acc     = (rd || wr) && (!sz || lane == 0);
    tmo     = acc && (lat == 0 || lat > TO);
    exp_err = ((rd || wr) && !acc) || tmo;
    src     = ssrc ? sd : imm;
    b       = int'((rdat >> (8 * lane)) & 16'h00FF);
    if (sgn && b >= 128) b = b - 256;
    ld       = !rd ? 16'h0 : (sz ? rdat : 16'(b));
    exp_data = exp_err ? 16'h0 : (sel == 0 ? p : sel == 1 ? alu : sel == 2 ? ld : imm);
    exp_be   = (wr && !sz) ? 2'(1 << lane) : 2'b11;
    exp_wd   = sz ? src : {src[7:0], src[7:0]};
    exp_lat  = !acc ? 1 : (tmo ? TO + 1 : lat + 1);

    in_valid = 1'b1; mem_rd = rd; mem_wr = wr; size = sz; load_signed = sgn;
    st_src = ssrc; wb_sel = sel; alu_result = alu; store_data = sd; immediate = imm; pc = p;
    done = -1; stall_cnt = 0; req_cnt = 0;
    for (int cyc = 0; cyc <= TO + 2; cyc++) begin
      if (cyc > 0 && wb_valid === 1'b1) begin
        done = cyc;
        break;
      end
      if (cyc > 0) begin
        in_valid = 1'b0;
        alu_result = 16'($urandom); pc = 16'($urandom); immediate = 16'($urandom);
        store_data = 16'($urandom); wb_sel = 2'($urandom); size = 1'($urandom);
        load_signed = 1'($urandom); st_src = 1'($urandom);
        mif.mem_rdata = (cyc == lat) ? rdat : 16'($urandom);
        mif.mem_ack   = (cyc == lat);
      end
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (cyc > 0 && mif.mem_req === 1'b1) req_cnt++;
      if (cyc > 0) chk("addr_held", mif.mem_addr, alu);
      if (cyc == 1) begin
        chk("req_we", mif.mem_we, wr);
        chk("req_be", mif.mem_be, exp_be);
        if (wr) chk("req_wdata", mif.mem_wdata, exp_wd);
      end
      @(posedge clk); #1;
    end
    mif.mem_ack = 1'b0;
    in_valid = 1'b0;
    chk("wb_cycle", done, exp_lat);
    chk("wb_data", wb_data, exp_data);
    chk("wb_err", wb_err, exp_err);
    chk("stall_cycles", stall_cnt, acc ? exp_lat : 0);
    chk("req_cycles", req_cnt, acc ? exp_lat - 1 : 0);
    chk("req_low_after", mif.mem_req, 1'b0);
    #1;
    chk("stall_after", stall, 1'b0);
    if (gap) begin
      @(posedge clk); #1;
      chk("wb_pulse", wb_valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, wr;
    int   kind;
    in_valid = 0; mem_rd = 0; mem_wr = 0; size = 0; load_signed = 0; st_src = 0;
    alu_result = 0; store_data = 0; immediate = 0; pc = 0; wb_sel = 0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mif.mem_req, 1'b0);
    chk("rst_we", mif.mem_we, 1'b0);
    chk("rst_addr", mif.mem_addr, 16'h0);
    chk("rst_wdata", mif.mem_wdata, 16'h0);
    chk("rst_be", mif.mem_be, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 16'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ALU passthrough, signed byte load, byte store, misaligned word.
    do_op(0, 0, 1, 0, 0, 2'd1, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    do_op(1, 0, 0, 1, 0, 2'd2, 16'h0011, 16'h0, 16'h0, 16'h0, 16'h80FF, 3, 1);
    do_op(0, 1, 0, 0, 0, 2'd1, 16'h0004, 16'h5555, 16'h00AB, 16'h0, 16'h0, 1, 1);
    do_op(1, 0, 1, 0, 0, 2'd2, 16'h0003, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1, 1);
    // Timeout, then an ack in the last allowed WAIT cycle.
    do_op(1, 0, 1, 0, 0, 2'd2, 16'h0020, 16'h0, 16'h0, 16'h0, 16'hCAFE, 0, 1);
    do_op(1, 0, 1, 0, 0, 2'd2, 16'h0020, 16'h0, 16'h0, 16'h0, 16'hCAFE, TO, 1);
    // Back-to-back: second instruction presented in the write-back cycle.
    do_op(1, 0, 0, 0, 0, 2'd2, 16'h0031, 16'h0, 16'h0, 16'h0, 16'h9A7F, 2, 0);
    do_op(0, 1, 1, 0, 1, 2'd0, 16'h0042, 16'hA5C3, 16'h0, 16'h0777, 16'h0, 1, 1);

    // Reset two cycles into WAIT, then a stray late ack.
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; size = 1'b1; wb_sel = 2'd2;
    alu_result = 16'h0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", mif.mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_req", mif.mem_req, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_wb_valid", wb_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h1111;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    chk("late_ack_wb", wb_valid, 1'b0);
    chk("late_ack_req", mif.mem_req, 1'b0);
    @(posedge clk); #1;
    chk("late_ack_wb2", wb_valid, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      rd = (kind == 1);
      wr = (kind == 2);
      do_op(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, TO + 1)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised memory stage for the pipeline processor, placed between the execute stage and write-back.
- Talks to data memory over a request/acknowledge handshake, so memory latency may vary.
- Stalls upstream while an access is outstanding and performs byte-lane steering for stores.
- Sign- or zero-extends loads and selects the write-back value.
- Flags misaligned accesses and memory timeouts.

Parameters:
DW, 16, datapath width in bits; multiple of 8, at least 16
AW, 16, memory address width in bits
TIMEOUT, 15, maximum cycles spent in WAIT before the access is abandoned; at least 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  an instruction is presented this cycle
alu_result  in  DW  effective address, or ALU value for write-back
store_data  in  DW  register operand for stores
immediate  in  DW  immediate operand
pc  in  DW  return PC for link write-back
mem_rd  in  1  load
mem_wr  in  1  store; mem_rd and mem_wr must never both be 1
size  in  1  0 = byte, 1 = full word
load_signed  in  1  byte load is sign-extended when 1, zero-extended when 0
st_src  in  1  store data source: 1 = store_data, 0 = immediate
wb_sel  in  2  write-back source: 0 = pc, 1 = alu_result, 2 = load data, 3 = immediate
mem_req  out  1  memory request
mem_we  out  1  request is a write
mem_addr  out  AW  request address
mem_wdata  out  DW  write data
mem_be  out  DW/8  byte enables
mem_rdata  in  DW  read data; valid only when mem_ack is 1
mem_ack  in  1  access complete
stall  out  1  upstream must hold its inputs stable
wb_valid  out  1  one-cycle pulse: wb_data and wb_err are valid
wb_data  out  DW  write-back value
wb_err  out  1  access was misaligned or timed out

Behaviour:
- Reset: every output is 0, state is IDLE, the timeout counter is 0. Reset asserted mid-access drops mem_req immediately; an mem_ack arriving afterwards is ignored.
- States: IDLE and WAIT.
- IDLE, in_valid=1, no memory op: on the next edge wb_valid=1 and wb_data is selected by wb_sel (load data reads as 0). Latency 1 cycle, no stall.
- IDLE, in_valid=1, memory op, aligned:
  - stall is asserted combinationally in that same cycle.
  - On the edge, all inputs are latched and the block enters WAIT with mem_req=1.
  - mem_addr, mem_we, mem_wdata and mem_be are registered and held constant for the whole of WAIT.
- Alignment rule: a word access is aligned when addr[log2(DW/8)-1:0] == 0. Byte accesses are always aligned.
- Misaligned word access:
  - No request is issued and the block stays in IDLE.
  - Next edge: wb_valid=1, wb_err=1, wb_data=0.
  - stall is not asserted.
- WAIT:
  - stall=1 and mem_req=1; the counter increments every cycle.
  - On mem_ack=1: capture mem_rdata, return to IDLE, drop mem_req on the next edge. On that same edge wb_valid=1 and wb_err=0, with wb_data per wb_sel.
  - Latency: for an ack L cycles after entering WAIT (L ≥ 1), wb_valid occurs L+1 cycles after acceptance.
  - If the counter reaches TIMEOUT without an ack: drop mem_req, return to IDLE, wb_valid=1, wb_err=1, wb_data=0.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success; the ack wins.
- stall equals (state==WAIT) OR (IDLE AND in_valid AND memory op AND aligned). stall is also 1 in the ack cycle.
- A new instruction may be accepted in the IDLE cycle immediately after WAIT, i.e. back-to-back.
- Byte store:
  - mem_be has exactly one bit set, at lane addr[log2(DW/8)-1:0].
  - mem_wdata is the store byte replicated across all lanes.
- Word store: mem_be is all ones; mem_wdata is the full source value.
- Loads: mem_be is all ones and mem_we=0.
- Byte load: select the lane by the address low bits, then extend to DW bits per load_signed.
- Stores: wb_valid still pulses; wb_data follows wb_sel, with load data reading as 0.
- wb_valid is held low in every cycle that does not complete an instruction.

Decomposition:
- Package mem_pkg:
  - WB_PC, WB_ALU, WB_MEM, WB_IMM encodings (wb_sel).
  - SZ_BYTE, SZ_WORD encodings (size).
  - State encodings ST_IDLE, ST_WAIT.
- Sub-module mem_load_align: combinational. Inputs are rdata, lane and signed flag; output is the extended load value. It is instantiated once for the load path.

Test Plan:
- ALU passthrough: DW=16, in_valid=1, mem_rd=0, mem_wr=0, wb_sel=1, alu_result=0x1234 → next cycle wb_valid=1, wb_data=0x1234, stall=0 throughout.
- Signed byte load: alu_result=0x0011, size=0, load_signed=1, mem_rdata=0x80FF, ack after 3 cycles → mem_be=2'b11; wb_data=0xFF80 four cycles after acceptance; stall high for exactly 4 cycles.
- Byte store: alu_result=0x0004, size=0, st_src=0, immediate=0x00AB, ack after 1 cycle → mem_we=1, mem_be=2'b01, mem_wdata=0xABAB.
- Misaligned word: alu_result=0x0003, size=1, mem_rd=1 → mem_req never rises; next cycle wb_valid=1, wb_err=1, wb_data=0.
- Timeout: TIMEOUT=4, mem_ack held low → mem_req high for 4 cycles then drops; wb_err=1. A repeat with ack arriving in exactly the 4th cycle yields wb_err=0.
- Reset mid-WAIT: assert reset 2 cycles into WAIT → mem_req, stall and wb_valid go to 0 immediately. A late mem_ack after reset release produces no wb_valid.
